twd_rot_mul: RTL and testbench

- Parametrised trivial-twiddle rotator for a radix-2/radix-4 FFT stage. It sits directly after the butterfly.
- Sum lanes pass through unchanged. Diff lanes are rotated by a per-block twiddle from {1, -j, -1, +j}, selected by an internal block counter.
- Supports forward and inverse (conjugate) direction, saturating negation, and a registered output with valid/index/frame-done tags.

---
 rtl/twd_pkg.sv | 48 ++++
 rtl/twd_rot_lane.sv | 51 +++++
 rtl/twd_rot_mul.sv | 110 +++++++++++
 tb/tb_twd_rot_mul.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/twd_pkg.sv
// Shared types and helpers for the trivial-twiddle rotator.
//   rot_e     : rotation applied to a diff lane, one of {1, -j, -1, +j}
//   rot_sel   : maps twiddle index and direction to a rotation
//   sat_neg   : width-aware negation with optional saturation
//   FRAME_LEN : blocks per frame for the default counter width
package twd_pkg;

  typedef enum logic [1:0] {
    ROT_P1 = 2'd0,  // multiply by 1
    ROT_NJ = 2'd1,  // multiply by -j
    ROT_N1 = 2'd2,  // multiply by -1
    ROT_PJ = 2'd3   // multiply by +j
  } rot_e;

  localparam int unsigned DEF_CNT_W = 4;
  localparam int unsigned FRAME_LEN = 2 ** DEF_CNT_W;

  // k counts through the twiddle sequence {1, -j, -1, +j}. The inverse transform uses the
  // conjugate twiddles, which only swaps -j and +j.
  function automatic rot_e rot_sel(input logic [1:0] k, input logic inv);
    rot_e r;
    unique case (k)
      2'd0:    r = ROT_P1;
      2'd1:    r = inv ? ROT_PJ : ROT_NJ;
      2'd2:    r = ROT_N1;
      default: r = inv ? ROT_NJ : ROT_PJ;
    endcase
    return r;
  endfunction

  // Negate a value that is `width` bits wide (sign-extended into 32 bits). The only
  // overflowing case is the most negative value: it either saturates to the most positive
  // value or wraps back onto itself. The caller truncates the result to `width` bits.
  // Valid for width in 2..32.
  function automatic logic signed [31:0] sat_neg(input logic signed [31:0] x,
                                                 input int unsigned      width,
                                                 input logic             sat);
    logic signed [31:0] min_v;
    logic signed [31:0] max_v;
    min_v = -(32'sd1 <<< (width - 1));
    max_v = (32'sd1 <<< (width - 1)) - 32'sd1;
    if (x == min_v) begin
      return sat ? max_v : min_v;
    end
    return -x;
  endfunction

endpackage

// File: rtl/twd_rot_lane.sv
// One complex lane of the trivial-twiddle rotator (purely combinational).
//   re_i, im_i : input sample components (signed, WIDTH bits)
//   rot_i      : rotation to apply
//   re_o, im_o : rotated sample components (signed, WIDTH bits, never widened)
module twd_rot_lane
  import twd_pkg::*;
#(
  parameter int unsigned WIDTH = 12,
  parameter bit          SAT   = 1'b1
) (
  input  logic signed [WIDTH-1:0] re_i,
  input  logic signed [WIDTH-1:0] im_i,
  input  rot_e                    rot_i,
  output logic signed [WIDTH-1:0] re_o,
  output logic signed [WIDTH-1:0] im_o
);

  logic signed [WIDTH-1:0] neg_re;
  logic signed [WIDTH-1:0] neg_im;

  assign neg_re = WIDTH'(sat_neg(32'(re_i), WIDTH, SAT));
  assign neg_im = WIDTH'(sat_neg(32'(im_i), WIDTH, SAT));

  always_comb begin
    re_o = re_i;
    im_o = im_i;
    unique case (rot_i)
      ROT_P1: begin
        re_o = re_i;
        im_o = im_i;
      end
      ROT_NJ: begin
        re_o = im_i;
        im_o = neg_re;
      end
      ROT_N1: begin
        re_o = neg_re;
        im_o = neg_im;
      end
      ROT_PJ: begin
        re_o = neg_im;
        im_o = re_i;
      end
      default: begin
        re_o = re_i;
        im_o = im_i;
      end
    endcase
  end

endmodule

// File: rtl/twd_rot_mul.sv
// Trivial-twiddle rotator placed after a radix-2/4 FFT butterfly.
// Sum lanes pass through; diff lanes are rotated by a per-block twiddle picked by a block
// counter. One block per clock, one cycle latency, no backpressure.
//   clk, rstn                : clock and synchronous active-high reset (rstn = 1 resets)
//   i_valid, i_inv           : block valid; inverse direction (taken on a frame's first beat)
//   i_sum_*/i_diff_*         : butterfly sum and difference lanes
//   o_valid                  : output block valid
//   o_sum_*/o_diff_*         : registered sum passthrough and rotated difference
//   o_blk_idx, o_frame_done  : block index of the output beat; pulse on a frame's last block
// ROT_BITS must not exceed CNT_W.
module twd_rot_mul
  import twd_pkg::*;
#(
  parameter int unsigned WIDTH    = 12,
  parameter int unsigned LANES    = 16,
  parameter int unsigned CNT_W    = 4,
  parameter int unsigned ROT_BITS = 1,
  parameter bit          SAT      = 1'b1
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    i_valid,
  input  logic                    i_inv,
  input  logic signed [WIDTH-1:0] i_sum_re  [0:LANES-1],
  input  logic signed [WIDTH-1:0] i_sum_im  [0:LANES-1],
  input  logic signed [WIDTH-1:0] i_diff_re [0:LANES-1],
  input  logic signed [WIDTH-1:0] i_diff_im [0:LANES-1],
  output logic                    o_valid,
  output logic signed [WIDTH-1:0] o_sum_re  [0:LANES-1],
  output logic signed [WIDTH-1:0] o_sum_im  [0:LANES-1],
  output logic signed [WIDTH-1:0] o_diff_re [0:LANES-1],
  output logic signed [WIDTH-1:0] o_diff_im [0:LANES-1],
  output logic [CNT_W-1:0]        o_blk_idx,
  output logic                    o_frame_done
);

  logic [CNT_W-1:0]        cnt_q;
  logic                    inv_q;
  logic [1:0]              k;
  logic                    inv_eff;
  rot_e                    rot;
  logic signed [WIDTH-1:0] rot_re [0:LANES-1];
  logic signed [WIDTH-1:0] rot_im [0:LANES-1];

  // The frame's first beat uses i_inv directly; later beats use the value latched then.
  assign k       = 2'(cnt_q[ROT_BITS-1:0]);
  assign inv_eff = (cnt_q == '0) ? i_inv : inv_q;
  assign rot     = rot_sel(k, inv_eff);

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    twd_rot_lane #(
      .WIDTH (WIDTH),
      .SAT   (SAT)
    ) u_lane (
      .re_i  (i_diff_re[l]),
      .im_i  (i_diff_im[l]),
      .rot_i (rot),
      .re_o  (rot_re[l]),
      .im_o  (rot_im[l])
    );
  end

  // Block counter and direction latch.
  always_ff @(posedge clk) begin
    if (rstn) begin
      cnt_q <= '0;
      inv_q <= 1'b0;
    end else if (i_valid) begin
      cnt_q <= cnt_q + 1'b1;
      if (cnt_q == '0) begin
        inv_q <= i_inv;
      end
    end
  end

  // Output tags: valid and frame-done are single-beat pulses.
  always_ff @(posedge clk) begin
    if (rstn) begin
      o_valid      <= 1'b0;
      o_frame_done <= 1'b0;
      o_blk_idx    <= '0;
    end else begin
      o_valid      <= i_valid;
      o_frame_done <= i_valid && (&cnt_q);
      if (i_valid) begin
        o_blk_idx <= cnt_q;
      end
    end
  end

  // Output data holds across gaps in i_valid.
  always_ff @(posedge clk) begin
    if (rstn) begin
      for (int l = 0; l < LANES; l++) begin
        o_sum_re[l]  <= '0;
        o_sum_im[l]  <= '0;
        o_diff_re[l] <= '0;
        o_diff_im[l] <= '0;
      end
    end else if (i_valid) begin
      for (int l = 0; l < LANES; l++) begin
        o_sum_re[l]  <= i_sum_re[l];
        o_sum_im[l]  <= i_sum_im[l];
        o_diff_re[l] <= rot_re[l];
        o_diff_im[l] <= rot_im[l];
      end
    end
  end

endmodule

// File: tb/tb_twd_rot_mul.sv
// Directed bench for twd_rot_mul. Three instances share stimulus:
//   a: ROT_BITS=1, SAT=1   b: ROT_BITS=2, SAT=1   c: ROT_BITS=1, SAT=0
module tb_twd_rot_mul;

  localparam int W  = 12;
  localparam int L  = 16;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic i_valid = 1'b0;
  logic i_inv = 1'b0;
  logic signed [W-1:0] sum_re [0:L-1];
  logic signed [W-1:0] sum_im [0:L-1];
  logic signed [W-1:0] diff_re [0:L-1];
  logic signed [W-1:0] diff_im [0:L-1];

  logic a_valid, b_valid, c_valid;
  logic a_done, b_done, c_done;
  logic [CW-1:0] a_idx, b_idx, c_idx;
  logic signed [W-1:0] a_sre [0:L-1], a_sim [0:L-1], a_dre [0:L-1], a_dim [0:L-1];
  logic signed [W-1:0] b_sre [0:L-1], b_sim [0:L-1], b_dre [0:L-1], b_dim [0:L-1];
  logic signed [W-1:0] c_sre [0:L-1], c_sim [0:L-1], c_dre [0:L-1], c_dim [0:L-1];

  int vectors = 0;
  int fails = 0;

  always #5 clk = ~clk;

  twd_rot_mul #(.WIDTH(W), .LANES(L), .CNT_W(CW), .ROT_BITS(1), .SAT(1'b1)) dut_a (
    .clk(clk), .rstn(rstn), .i_valid(i_valid), .i_inv(i_inv),
    .i_sum_re(sum_re), .i_sum_im(sum_im), .i_diff_re(diff_re), .i_diff_im(diff_im),
    .o_valid(a_valid), .o_sum_re(a_sre), .o_sum_im(a_sim), .o_diff_re(a_dre),
    .o_diff_im(a_dim), .o_blk_idx(a_idx), .o_frame_done(a_done)
  );

  twd_rot_mul #(.WIDTH(W), .LANES(L), .CNT_W(CW), .ROT_BITS(2), .SAT(1'b1)) dut_b (
    .clk(clk), .rstn(rstn), .i_valid(i_valid), .i_inv(i_inv),
    .i_sum_re(sum_re), .i_sum_im(sum_im), .i_diff_re(diff_re), .i_diff_im(diff_im),
    .o_valid(b_valid), .o_sum_re(b_sre), .o_sum_im(b_sim), .o_diff_re(b_dre),
    .o_diff_im(b_dim), .o_blk_idx(b_idx), .o_frame_done(b_done)
  );

  twd_rot_mul #(.WIDTH(W), .LANES(L), .CNT_W(CW), .ROT_BITS(1), .SAT(1'b0)) dut_c (
    .clk(clk), .rstn(rstn), .i_valid(i_valid), .i_inv(i_inv),
    .i_sum_re(sum_re), .i_sum_im(sum_im), .i_diff_re(diff_re), .i_diff_im(diff_im),
    .o_valid(c_valid), .o_sum_re(c_sre), .o_sum_im(c_sim), .o_diff_re(c_dre),
    .o_diff_im(c_dim), .o_blk_idx(c_idx), .o_frame_done(c_done)
  );

  task automatic set_data(input int sr, input int si, input int dr, input int di);
    for (int l = 0; l < L; l++) begin
      sum_re[l]  = W'(sr);
      sum_im[l]  = W'(si);
      diff_re[l] = W'(dr);
      diff_im[l] = W'(di);
    end
  endtask

  // Apply one clock with the given valid, then settle just after the edge.
  task automatic step(input logic v);
    i_valid = v;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    i_valid = 1'b0;
    rstn = 1'b1;
    @(posedge clk);
    #1;
    rstn = 1'b0;
  endtask

  task automatic test_reset();
    set_data(11, 22, 33, 44);
    i_valid = 1'b1;
    rstn = 1'b1;
    @(posedge clk);
    #1;
    rstn = 1'b0;
    i_valid = 1'b0;
    vectors++;
    if (a_valid !== 1'b0 || a_done !== 1'b0 || a_idx !== 4'd0) begin
      $display("FAIL reset_tags: got valid=%b done=%b idx=%0d want 0 0 0",
               a_valid, a_done, a_idx);
      fails++;
    end
    vectors++;
    if (int'(a_sre[0]) !== 0 || int'(a_sim[L-1]) !== 0 || int'(b_dre[0]) !== 0
        || int'(b_dim[L-1]) !== 0) begin
      $display("FAIL reset_data: got sum=(%0d,%0d) diff=(%0d,%0d) want all 0",
               a_sre[0], a_sim[L-1], b_dre[0], b_dim[L-1]);
      fails++;
    end
  endtask

  task automatic test_rot1();
    int er[4] = '{100, -50, 100, -50};
    int ei[4] = '{-50, -100, -50, -100};
    do_reset();
    i_inv = 1'b0;
    set_data(7, 9, 100, -50);
    for (int i = 0; i < 4; i++) begin
      step(1'b1);
      vectors++;
      if (a_valid !== 1'b1 || a_idx !== 4'(i)) begin
        $display("FAIL rot1_tag beat %0d: got valid=%b idx=%0d want 1 %0d", i, a_valid, a_idx, i);
        fails++;
      end
      vectors++;
      if (int'(a_dre[0]) !== er[i] || int'(a_dim[L-1]) !== ei[i]) begin
        $display("FAIL rot1_diff beat %0d: got (%0d,%0d) want (%0d,%0d)",
                 i, a_dre[0], a_dim[L-1], er[i], ei[i]);
        fails++;
      end
      vectors++;
      if (int'(a_sre[3]) !== 7 || int'(a_sim[0]) !== 9) begin
        $display("FAIL rot1_sum beat %0d: got (%0d,%0d) want (7,9)", i, a_sre[3], a_sim[0]);
        fails++;
      end
    end
    step(1'b0);
    vectors++;
    if (a_valid !== 1'b0) begin
      $display("FAIL rot1_idle: got valid=%b want 0", a_valid);
      fails++;
    end
  endtask

  task automatic test_rot2();
    int er[4] = '{300, 200, -300, -200};
    int ei[4] = '{200, -300, -200, 300};
    do_reset();
    i_inv = 1'b0;
    set_data(1, 2, 300, 200);
    for (int i = 0; i < 4; i++) begin
      step(1'b1);
      vectors++;
      if (int'(b_dre[5]) !== er[i] || int'(b_dim[5]) !== ei[i] || b_idx !== 4'(i)) begin
        $display("FAIL rot2_diff beat %0d: got (%0d,%0d) idx=%0d want (%0d,%0d) idx=%0d",
                 i, b_dre[5], b_dim[5], b_idx, er[i], ei[i], i);
        fails++;
      end
    end
  endtask

  task automatic test_inv();
    int er[4] = '{300, -200, -300, 200};
    int ei[4] = '{200, 300, -200, -300};
    do_reset();
    set_data(1, 2, 300, 200);
    for (int i = 0; i < 4; i++) begin
      i_inv = (i == 0);
      step(1'b1);
      vectors++;
      if (int'(b_dre[L-1]) !== er[i] || int'(b_dim[0]) !== ei[i]) begin
        $display("FAIL inv_diff beat %0d: got (%0d,%0d) want (%0d,%0d)",
                 i, b_dre[L-1], b_dim[0], er[i], ei[i]);
        fails++;
      end
    end
    i_inv = 1'b0;
  endtask

  task automatic test_sat();
    do_reset();
    i_inv = 1'b0;
    set_data(0, 0, -2048, 5);
    step(1'b1);
    step(1'b1);
    vectors++;
    if (int'(a_dre[0]) !== 5 || int'(a_dim[0]) !== 2047) begin
      $display("FAIL sat_on: got (%0d,%0d) want (5,2047)", a_dre[0], a_dim[0]);
      fails++;
    end
    vectors++;
    if (int'(c_dre[0]) !== 5 || int'(c_dim[0]) !== -2048) begin
      $display("FAIL sat_off: got (%0d,%0d) want (5,-2048)", c_dre[0], c_dim[0]);
      fails++;
    end
  endtask

  task automatic test_gaps();
    logic [CW-1:0] exp_idx;
    logic [CW-1:0] last_idx;
    int            last_sum;
    int            done_cnt;
    logic          v;
    do_reset();
    exp_idx  = '0;
    last_idx = '0;
    last_sum = 0;
    done_cnt = 0;
    // 1,0,0,1 then 14 more valid beats, then one beat into the next frame.
    for (int i = 0; i < 19; i++) begin
      v = !(i == 1 || i == 2);
      set_data(v ? 10 + i : 999, 0, 0, 0);
      step(v);
      if (a_done === 1'b1) done_cnt++;
      vectors++;
      if (v) begin
        if (a_valid !== 1'b1 || a_idx !== exp_idx || int'(a_sre[0]) !== 10 + i
            || a_done !== (exp_idx == 4'd15)) begin
          $display("FAIL gap_beat %0d: got valid=%b idx=%0d sum=%0d done=%b want 1 %0d %0d %b",
                   i, a_valid, a_idx, a_sre[0], a_done, exp_idx, 10 + i, exp_idx == 4'd15);
          fails++;
        end
        last_idx = exp_idx;
        last_sum = 10 + i;
        exp_idx  = exp_idx + 1'b1;
      end else begin
        if (a_valid !== 1'b0 || a_done !== 1'b0 || a_idx !== last_idx
            || int'(a_sre[0]) !== last_sum) begin
          $display("FAIL gap_hold %0d: got valid=%b done=%b idx=%0d sum=%0d want 0 0 %0d %0d",
                   i, a_valid, a_done, a_idx, a_sre[0], last_idx, last_sum);
          fails++;
        end
      end
    end
    vectors++;
    if (done_cnt !== 1 || a_idx !== 4'd0) begin
      $display("FAIL gap_done_count: got pulses=%0d last_idx=%0d want 1 0", done_cnt, a_idx);
      fails++;
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    i_inv = 1'b0;
    set_data(4, 6, 300, 200);
    for (int i = 0; i < 5; i++) step(1'b1);
    i_valid = 1'b1;
    rstn = 1'b1;
    @(posedge clk);
    #1;
    rstn = 1'b0;
    vectors++;
    if (b_valid !== 1'b0 || b_done !== 1'b0 || b_idx !== 4'd0 || int'(b_dre[0]) !== 0
        || int'(b_sim[0]) !== 0) begin
      $display("FAIL midreset_clear: got valid=%b done=%b idx=%0d diff_re=%0d sum_im=%0d want 0",
               b_valid, b_done, b_idx, b_dre[0], b_sim[0]);
      fails++;
    end
    step(1'b1);
    vectors++;
    if (b_valid !== 1'b1 || b_idx !== 4'd0 || int'(b_dre[0]) !== 300
        || int'(b_dim[0]) !== 200) begin
      $display("FAIL midreset_next: got valid=%b idx=%0d diff=(%0d,%0d) want 1 0 (300,200)",
               b_valid, b_idx, b_dre[0], b_dim[0]);
      fails++;
    end
    i_valid = 1'b0;
  endtask

  initial begin
    set_data(0, 0, 0, 0);
    #2;
    test_reset();
    test_rot1();
    test_rot2();
    test_inv();
    test_sat();
    test_gaps();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
